regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Initiator side of the 16 x 19-bit register file interface; the register file is the responder.
- Accepts decoded instructions, drives the register file read ports, and captures operands into an issue register for the execute stage.
- Accepts execute results and drives the register file write port one cycle later.
- Tracks in-flight destinations with a 16-bit busy scoreboard and forwards same-cycle writebacks to operand reads.

Parameters:
DATA_W, 19, register data width
ADDR_W, 4, register address width
NREG, 16, number of registers (2**ADDR_W)
OP_W, 5, opaque opcode width passed through to execute

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
dec_valid  in  1  decoded instruction valid
dec_ready  out  1  instruction accepted this cycle when dec_valid and dec_ready are both high
dec_op  in  OP_W  opcode
dec_rs1, dec_rs2, dec_rd  in  ADDR_W each  source and destination register indices
dec_use_rs1, dec_use_rs2, dec_wr_rd  in  1 each  operand/destination enables
read_reg1, read_reg2  out  ADDR_W  register file read addresses (combinational from dec_rs1/dec_rs2)
read_data1, read_data2  in  DATA_W  register file read data (combinational read)
write_reg  out  ADDR_W  register file write address
write_data  out  DATA_W  register file write data
reg_write  out  1  register file write enable (file writes on rising edge)
ex_valid  out  1  issue register valid
ex_ready  in  1  execute stage accepts
ex_op  out  OP_W  issued opcode
ex_rd  out  ADDR_W  issued destination
ex_wr_rd  out  1  issued destination enable
ex_a, ex_b  out  DATA_W  issued operands
res_valid  in  1  result return valid (always accepted)
res_rd  in  ADDR_W  result destination
res_data  in  DATA_W  result value
busy  out  NREG  scoreboard, for debug
wb_err  out  1  sticky flag: result returned to a non-busy register

Behaviour:
- Reset (synchronous, rst high at an edge):
  - ex_valid, reg_write, wb_err, busy and all registered data/address outputs clear to 0.
  - dec_ready is forced 0 while rst is high.
  - Reset mid-operation discards the pending issue and any staged writeback; no register file write occurs in the cycle after reset.
- Writeback stage:
  - res_* is sampled at edge M into the wb register.
  - During the following cycle, reg_write=1, write_reg=res_rd and write_data=res_data.
  - The register file writes, and busy[res_rd] clears, at edge M+1.
  - If busy[res_rd]=0 when sampled: the write still happens and wb_err sets, held until reset.
- Bypass:
  - If reg_write=1 and write_reg equals dec_rs1 (or dec_rs2), the operand is taken from write_data instead of read_data1 (read_data2).
  - That register is treated as not busy for the hazard check.
- Hazard (all terms qualified by the register not being written back this cycle):
  - RAW: dec_use_rs1 with busy[dec_rs1], or dec_use_rs2 with busy[dec_rs2].
  - WAW: dec_wr_rd with busy[dec_rd].
- Ready: dec_ready = !rst && !hazard && (!ex_valid || ex_ready).
- Accept at edge N:
  - ex_* loads the operands; unused operands load 0.
  - ex_valid=1 from cycle N+1, giving 1-cycle latency.
  - busy[dec_rd] sets if dec_wr_rd.
- Set and clear of the same busy bit at one edge: set wins.
- Issue register:
  - Clears when ex_ready && ex_valid with no new accept.
  - All ex_* are held stable while ex_valid && !ex_ready.
- Back-to-back accepts with ex_ready=1 give one instruction per cycle.
- Indices wrap within ADDR_W; there is no special zero register.

Decomposition:
- Shared package rf_pkg holds DATA_W, ADDR_W, NREG and OP_W, shared with regfile and the execute stage.
- One natural sub-module: rf_scoreboard, which holds the busy vector, set/clear ports and the hazard query.
- Bypass muxes and the issue register stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles -> busy=0, ex_valid=0, reg_write=0, wb_err=0, dec_ready=0 during reset and 1 after.
- Writeback then read:
  - Stimulus: res r1=25, then res r2=50; then issue rs1=1, rs2=2, use both.
  - Required: reg_write pulses with write_reg 1 then 2; next cycle ex_a=25, ex_b=50, ex_valid=1.
- RAW stall with bypass:
  - Stimulus: issue rd=3 (wr_rd=1) -> busy[3]=1; then issue rs1=3.
  - Required: dec_ready=0 until res r3=100 is sampled. In the reg_write cycle for r3, dec_ready=1 and ex_a=100 arrives via bypass; busy[3]=0 afterwards.
- Backpressure:
  - Stimulus: ex_ready=0 with ex_valid=1, second instruction valid.
  - Required: dec_ready=0 and ex_a/ex_b/ex_op unchanged for 3 cycles; ex_ready=1 accepts the second instruction the next cycle.
- WAW and error:
  - Stimulus: issue rd=5, then a second issue with rd=5; separately, res r7 with busy[7]=0.
  - Required: the second issue stalls until r5 writes back; for r7 the write occurs and wb_err=1, held.
- Reset mid-op:
  - Stimulus: busy[4]=1, ex_valid=1, res sampled for r4; assert rst.
  - Required: the next cycle has reg_write=0, ex_valid=0, busy=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file parameters and types used by the access controller,
// the register file and the execute stage.
package rf_pkg;

    localparam int unsigned DATA_W = 19;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NREG   = 1 << ADDR_W;
    localparam int unsigned OP_W   = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [NREG-1:0]   mask_t;
    typedef logic [OP_W-1:0]   op_t;

    typedef struct packed {
        logic  valid;
        op_t   op;
        addr_t rd;
        logic  wr_rd;
        data_t a;
        data_t b;
    } issue_t;

    typedef struct packed {
        logic  valid;
        addr_t rd;
        data_t data;
    } wb_t;

    function automatic mask_t reg_mask(input addr_t idx);
        mask_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for in-flight destinations; answers the RAW/WAW hazard query
// with the register being written back this cycle already treated as free.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    input  logic              use_rs1_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic              use_rs2_i,
    input  logic [ADDR_W-1:0] rs2_i,
    input  logic              wr_rd_i,
    input  logic [ADDR_W-1:0] rd_i,
    output logic [NREG-1:0]   busy_o,
    output logic              hazard_o
);

    mask_t busy_q, busy_d;
    mask_t busy_eff;

    always_comb begin
        busy_eff = busy_q;
        if (clr_en_i) begin
            busy_eff = busy_q & ~reg_mask(clr_idx_i);
        end
    end

    always_comb begin
        hazard_o = (use_rs1_i && busy_eff[rs1_i]) ||
                   (use_rs2_i && busy_eff[rs2_i]) ||
                   (wr_rd_i   && busy_eff[rd_i]);
    end

    // Applying the set after the clear makes a same-edge set win.
    always_comb begin
        busy_d = busy_eff;
        if (set_en_i) begin
            busy_d = busy_d | reg_mask(set_idx_i);
        end
        if (rst_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: reads operands for decoded instructions into the issue
// register, stages execute results onto the write port and guards hazards.
module regfile_access_ctrl
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [OP_W-1:0]   dec_op,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic [ADDR_W-1:0] dec_rd,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic              dec_wr_rd,
    output logic [ADDR_W-1:0] read_reg1,
    output logic [ADDR_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [OP_W-1:0]   ex_op,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_wr_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_rd,
    input  logic [DATA_W-1:0] res_data,
    output logic [NREG-1:0]   busy,
    output logic              wb_err
);

    issue_t issue_q, issue_d;
    wb_t    wb_q, wb_d;
    logic   wb_err_q, wb_err_d;
    logic   hazard;
    logic   accept;
    logic   byp1, byp2;
    data_t  opnd_a, opnd_b;
    mask_t  busy_vec;

    assign read_reg1  = dec_rs1;
    assign read_reg2  = dec_rs2;

    assign reg_write  = wb_q.valid;
    assign write_reg  = wb_q.rd;
    assign write_data = wb_q.data;

    assign ex_valid   = issue_q.valid;
    assign ex_op      = issue_q.op;
    assign ex_rd      = issue_q.rd;
    assign ex_wr_rd   = issue_q.wr_rd;
    assign ex_a       = issue_q.a;
    assign ex_b       = issue_q.b;

    assign busy       = busy_vec;
    assign wb_err     = wb_err_q;

    rf_scoreboard u_scoreboard (
        .clk_i     (clk),
        .rst_i     (rst),
        .set_en_i  (accept && dec_wr_rd),
        .set_idx_i (dec_rd),
        .clr_en_i  (wb_q.valid),
        .clr_idx_i (wb_q.rd),
        .use_rs1_i (dec_use_rs1),
        .rs1_i     (dec_rs1),
        .use_rs2_i (dec_use_rs2),
        .rs2_i     (dec_rs2),
        .wr_rd_i   (dec_wr_rd),
        .rd_i      (dec_rd),
        .busy_o    (busy_vec),
        .hazard_o  (hazard)
    );

    // The file has not yet absorbed the staged write, so forward it.
    always_comb begin
        byp1   = wb_q.valid && (wb_q.rd == dec_rs1);
        byp2   = wb_q.valid && (wb_q.rd == dec_rs2);
        opnd_a = '0;
        opnd_b = '0;
        if (dec_use_rs1) begin
            opnd_a = byp1 ? wb_q.data : read_data1;
        end
        if (dec_use_rs2) begin
            opnd_b = byp2 ? wb_q.data : read_data2;
        end
    end

    always_comb begin
        dec_ready = !rst && !hazard && (!issue_q.valid || ex_ready);
        accept    = dec_valid && dec_ready;
    end

    always_comb begin
        issue_d = issue_q;
        if (accept) begin
            issue_d = '{valid: 1'b1, op: dec_op, rd: dec_rd, wr_rd: dec_wr_rd,
                        a: opnd_a, b: opnd_b};
        end else if (issue_q.valid && ex_ready) begin
            issue_d.valid = 1'b0;
        end
        if (rst) begin
            issue_d = '0;
        end
    end

    always_comb begin
        wb_d     = '{valid: res_valid, rd: res_rd, data: res_data};
        wb_err_d = wb_err_q || (res_valid && !busy_vec[res_rd]);
        if (rst) begin
            wb_d     = '0;
            wb_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        issue_q  <= issue_d;
        wb_q     <= wb_d;
        wb_err_q <= wb_err_d;
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the controller.
module tb_regfile_access_ctrl;
    import rf_pkg::*;

    logic              clk;
    logic              rst;
    logic              dec_valid;
    logic              dec_ready;
    logic [OP_W-1:0]   dec_op;
    logic [ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
    logic              dec_use_rs1, dec_use_rs2, dec_wr_rd;
    logic [ADDR_W-1:0] read_reg1, read_reg2;
    logic [DATA_W-1:0] read_data1, read_data2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic              ex_valid, ex_ready;
    logic [OP_W-1:0]   ex_op;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_wr_rd;
    logic [DATA_W-1:0] ex_a, ex_b;
    logic              res_valid;
    logic [ADDR_W-1:0] res_rd;
    logic [DATA_W-1:0] res_data;
    logic [NREG-1:0]   busy;
    logic              wb_err;

    regfile_access_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_op      (dec_op),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .dec_wr_rd   (dec_wr_rd),
        .read_reg1   (read_reg1),
        .read_reg2   (read_reg2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_op       (ex_op),
        .ex_rd       (ex_rd),
        .ex_wr_rd    (ex_wr_rd),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .res_valid   (res_valid),
        .res_rd      (res_rd),
        .res_data    (res_data),
        .busy        (busy),
        .wb_err      (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file responder: combinational read, write on rising edge.
    logic [DATA_W-1:0] rf_mem [NREG] = '{default: '0};
    assign read_data1 = rf_mem[read_reg1];
    assign read_data2 = rf_mem[read_reg2];
    always @(posedge clk) begin
        if (reg_write === 1'b1) rf_mem[write_reg] <= write_data;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: register contents, in-flight destinations, staged write, issue slot.
    logic [DATA_W-1:0] m_rf [NREG] = '{default: '0};
    bit                m_busy [NREG];
    bit                m_err;
    bit                m_wb_v;
    logic [ADDR_W-1:0] m_wb_rd;
    logic [DATA_W-1:0] m_wb_data;
    bit                m_ex_v;
    logic [OP_W-1:0]   m_ex_op;
    logic [ADDR_W-1:0] m_ex_rd;
    bit                m_ex_wr;
    logic [DATA_W-1:0] m_ex_a, m_ex_b;
    bit                chk_en;
    bit                auto_exec;
    logic [ADDR_W-1:0] pending [$];

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_err  = 1'b0;
        m_wb_v = 1'b0;
        m_ex_v = 1'b0;
        pending.delete();
    endtask

    function automatic bit blocked(input logic [ADDR_W-1:0] r);
        return m_busy[r] && !(m_wb_v && m_wb_rd == r);
    endfunction

    // One clock: compare DUT against model, then advance model across the edge.
    task automatic step();
        bit                exp_rdy, acc, hs;
        logic [NREG-1:0]   exp_busy;
        logic [DATA_W-1:0] na, nb;
        #1;
        exp_rdy = !rst && (!m_ex_v || ex_ready) &&
                  !((dec_use_rs1 && blocked(dec_rs1)) ||
                    (dec_use_rs2 && blocked(dec_rs2)) ||
                    (dec_wr_rd && blocked(dec_rd)));
        acc = dec_valid && exp_rdy;
        hs  = m_ex_v && ex_ready && !rst;
        for (int i = 0; i < NREG; i++) exp_busy[i] = m_busy[i];
        if (chk_en) begin
            chk("dec_ready", 32'(dec_ready), 32'(exp_rdy));
            chk("read_reg1", 32'(read_reg1), 32'(dec_rs1));
            chk("read_reg2", 32'(read_reg2), 32'(dec_rs2));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("wb_err", 32'(wb_err), 32'(m_err));
            chk("reg_write", 32'(reg_write), 32'(m_wb_v));
            if (m_wb_v) begin
                chk("write_reg", 32'(write_reg), 32'(m_wb_rd));
                chk("write_data", 32'(write_data), 32'(m_wb_data));
            end
            chk("ex_valid", 32'(ex_valid), 32'(m_ex_v));
            if (m_ex_v) begin
                chk("ex_op", 32'(ex_op), 32'(m_ex_op));
                chk("ex_rd", 32'(ex_rd), 32'(m_ex_rd));
                chk("ex_wr_rd", 32'(ex_wr_rd), 32'(m_ex_wr));
                chk("ex_a", 32'(ex_a), 32'(m_ex_a));
                chk("ex_b", 32'(ex_b), 32'(m_ex_b));
            end
        end
        na = '0;
        nb = '0;
        if (dec_use_rs1) na = (m_wb_v && m_wb_rd == dec_rs1) ? m_wb_data : m_rf[dec_rs1];
        if (dec_use_rs2) nb = (m_wb_v && m_wb_rd == dec_rs2) ? m_wb_data : m_rf[dec_rs2];
        @(posedge clk);
        if (m_wb_v) m_rf[m_wb_rd] = m_wb_data;
        if (rst) begin
            model_clear();
        end else begin
            if (auto_exec && hs && m_ex_wr) pending.push_back(m_ex_rd);
            if (res_valid && !m_busy[res_rd]) m_err = 1'b1;
            if (m_wb_v) m_busy[m_wb_rd] = 1'b0;
            if (acc && dec_wr_rd) m_busy[dec_rd] = 1'b1;
            m_wb_v    = res_valid;
            m_wb_rd   = res_rd;
            m_wb_data = res_data;
            if (acc) begin
                m_ex_v  = 1'b1;
                m_ex_op = dec_op;
                m_ex_rd = dec_rd;
                m_ex_wr = dec_wr_rd;
                m_ex_a  = na;
                m_ex_b  = nb;
            end else if (hs) begin
                m_ex_v = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid   = 1'b0;
        dec_op      = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_rd      = '0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_wr_rd   = 1'b0;
        ex_ready    = 1'b1;
        res_valid   = 1'b0;
        res_rd      = '0;
        res_data    = '0;
    endtask

    task automatic set_dec(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rs1,
                           input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd,
                           input logic u1, input logic u2, input logic w);
        dec_valid   = 1'b1;
        dec_op      = op;
        dec_rs1     = rs1;
        dec_rs2     = rs2;
        dec_rd      = rd;
        dec_use_rs1 = u1;
        dec_use_rs2 = u2;
        dec_wr_rd   = w;
    endtask

    task automatic set_res(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        res_valid = 1'b1;
        res_rd    = rd;
        res_data  = data;
    endtask

    initial begin
        int k;
        model_clear();
        auto_exec = 1'b0;
        idle_inputs();

        // Reset for two cycles
        rst    = 1'b1;
        chk_en = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_reg_write", 32'(reg_write), 32'h0);
        chk("rst_wb_err", 32'(wb_err), 32'h0);
        chk("rst_dec_ready", 32'(dec_ready), 32'h0);
        rst = 1'b0;
        #1 chk("post_rst_dec_ready", 32'(dec_ready), 32'h1);

        // Writeback then read
        set_dec(5'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
        step();
        set_dec(5'd0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1);
        step();
        chk("wr_busy_12", 32'(busy), 32'h6);
        chk("wr_ex_rd", 32'(ex_rd), 32'h2);
        idle_inputs();
        set_res(4'd1, 19'd25);
        step();
        chk("wr1_reg_write", 32'(reg_write), 32'h1);
        chk("wr1_write_reg", 32'(write_reg), 32'h1);
        chk("wr1_write_data", 32'(write_data), 32'd25);
        set_res(4'd2, 19'd50);
        step();
        chk("wr2_write_reg", 32'(write_reg), 32'h2);
        chk("wr2_busy", 32'(busy), 32'h4);
        res_valid = 1'b0;
        set_dec(5'd4, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0);
        step();
        chk("rd_ex_a", 32'(ex_a), 32'd25);
        chk("rd_ex_b", 32'(ex_b), 32'd50);
        chk("rd_ex_valid", 32'(ex_valid), 32'h1);
        chk("rd_busy", 32'(busy), 32'h0);
        idle_inputs();
        step();

        // RAW stall released by bypass
        set_dec(5'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("raw_busy3", 32'(busy), 32'h8);
        set_dec(5'h0a, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        #1 chk("raw_stall0", 32'(dec_ready), 32'h0);
        step();
        step();
        set_res(4'd3, 19'd100);
        #1 chk("raw_stall_sample", 32'(dec_ready), 32'h0);
        step();
        res_valid = 1'b0;
        #1 chk("raw_release", 32'(dec_ready), 32'h1);
        step();
        chk("raw_ex_a", 32'(ex_a), 32'd100);
        chk("raw_ex_op", 32'(ex_op), 32'h0a);
        chk("raw_busy_after", 32'(busy), 32'h0);
        idle_inputs();
        step();

        // Backpressure holds the issue register
        ex_ready = 1'b0;
        set_dec(5'd7, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0);
        step();
        chk("bp_first_op", 32'(ex_op), 32'd7);
        set_dec(5'd9, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_dec_ready", 32'(dec_ready), 32'h0);
            step();
            chk("bp_hold_op", 32'(ex_op), 32'd7);
            chk("bp_hold_a", 32'(ex_a), 32'd25);
            chk("bp_hold_b", 32'(ex_b), 32'd50);
        end
        ex_ready = 1'b1;
        #1 chk("bp_release", 32'(dec_ready), 32'h1);
        step();
        chk("bp_second_op", 32'(ex_op), 32'd9);
        chk("bp_second_a", 32'(ex_a), 32'd100);
        idle_inputs();
        step();

        // WAW stall, same-edge set/clear, and the error flag
        set_dec(5'd1, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1);
        step();
        set_dec(5'd3, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1);
        #1 chk("waw_stall", 32'(dec_ready), 32'h0);
        step();
        set_res(4'd5, 19'd77);
        #1 chk("waw_stall_sample", 32'(dec_ready), 32'h0);
        step();
        res_valid = 1'b0;
        #1 chk("waw_release", 32'(dec_ready), 32'h1);
        step();
        chk("waw_set_wins", 32'(busy), 32'h20);
        chk("waw_ex_op", 32'(ex_op), 32'd3);
        dec_valid = 1'b0;
        set_res(4'd5, 19'd88);
        step();
        res_valid = 1'b0;
        step();
        chk("waw_busy_clear", 32'(busy), 32'h0);
        chk("waw_no_err", 32'(wb_err), 32'h0);
        set_res(4'd7, 19'd11);
        step();
        chk("err_set", 32'(wb_err), 32'h1);
        res_valid = 1'b0;
        #1 chk("err_write_reg", 32'(write_reg), 32'h7);
        chk("err_reg_write", 32'(reg_write), 32'h1);
        step();
        step();
        chk("err_held", 32'(wb_err), 32'h1);

        // Reset mid-operation
        set_dec(5'd2, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1);
        step();
        chk("mid_busy4", 32'(busy), 32'h10);
        dec_valid = 1'b0;
        ex_ready  = 1'b0;
        set_res(4'd4, 19'd44);
        rst = 1'b1;
        step();
        chk("mid_reg_write", 32'(reg_write), 32'h0);
        chk("mid_ex_valid", 32'(ex_valid), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_wb_err", 32'(wb_err), 32'h0);
        rst = 1'b0;
        idle_inputs();
        step();

        // Randomized traffic; the bench plays the execute stage
        auto_exec = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst         = ($urandom_range(0, 499) == 0);
            dec_valid   = ($urandom_range(0, 9) < 7);
            dec_op      = OP_W'($urandom);
            dec_rs1     = ADDR_W'($urandom);
            dec_rs2     = ADDR_W'($urandom);
            dec_rd      = ADDR_W'($urandom);
            dec_use_rs1 = 1'($urandom);
            dec_use_rs2 = 1'($urandom);
            dec_wr_rd   = 1'($urandom);
            ex_ready    = ($urandom_range(0, 3) != 0);
            res_valid   = 1'b0;
            res_rd      = '0;
            res_data    = DATA_W'($urandom);
            if (pending.size() > 0 && $urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, pending.size() - 1);
                res_valid = 1'b1;
                res_rd    = pending[k];
                pending.delete(k);
            end else if ($urandom_range(0, 199) == 0) begin
                res_valid = 1'b1;
                res_rd    = ADDR_W'($urandom);
            end
            step();
        end

        idle_inputs();
        rst = 1'b0;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
